// File: rtl/gshare_if.sv
// gshare_if: fetch/resolve side signals of the gshare predictor
interface gshare_if #(
    parameter int PC_W   = 8,
    parameter int IDX_W  = 4,
    parameter int HIST_W = 4
);
    logic              pred_req;
    logic [PC_W-1:0]   pred_pc;
    logic              pred_valid;
    logic              pred_taken;
    logic [IDX_W-1:0]  pred_idx;
    logic              upd_valid;
    logic [IDX_W-1:0]  upd_idx;
    logic              upd_taken;
    logic [HIST_W-1:0] ghr_out;
    modport master (
        output pred_req, pred_pc, upd_valid, upd_idx, upd_taken,
        input  pred_valid, pred_taken, pred_idx, ghr_out
    );
    modport slave (
        input  pred_req, pred_pc, upd_valid, upd_idx, upd_taken,
        output pred_valid, pred_taken, pred_idx, ghr_out
    );
endinterface

// File: rtl/gshare_predictor.sv
// gshare_predictor: PC^GHR indexed 2-bit counter branch predictor, 1-cycle prediction.
// GSHARE_FWD_EN: forward a same-cycle update of the predicted entry into pred_taken.
module gshare_predictor #(
    parameter int PC_W   = 8,
    parameter int IDX_W  = 4,
    parameter int HIST_W = 4
) (
    input logic      clk,
    input logic      rst,
    gshare_if.slave  bus
);
    logic [1:0]        pht [2**IDX_W];
    logic [HIST_W-1:0] ghr;
    logic [HIST_W-1:0] ghr_nxt;
    logic [IDX_W-1:0]  idx;
    logic [1:0]        upd_cur;
    logic [1:0]        upd_cnt;
    logic              taken_c;
    logic              pv;
    logic              pt;
    logic [IDX_W-1:0]  pi;
    always_comb begin
        idx     = bus.pred_pc[IDX_W-1:0] ^ IDX_W'(ghr);
        upd_cur = pht[bus.upd_idx];
        upd_cnt = bus.upd_taken ? ((upd_cur == 2'b11) ? 2'b11 : upd_cur + 2'b01)
                                : ((upd_cur == 2'b00) ? 2'b00 : upd_cur - 2'b01);
        // truncating {ghr, taken} drops the oldest bit, also correct for HIST_W=1
        ghr_nxt = HIST_W'({ghr, bus.upd_taken});
`ifdef GSHARE_FWD_EN
        taken_c = (bus.upd_valid && idx == bus.upd_idx) ? upd_cnt[1] : pht[idx][1];
`else
        taken_c = pht[idx][1];
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**IDX_W; i++) pht[i] <= 2'b01;
            ghr <= '0;
            pv  <= 1'b0;
            pt  <= 1'b0;
            pi  <= '0;
        end else begin
            pv <= bus.pred_req;
            if (bus.pred_req) begin
                pt <= taken_c;
                pi <= idx;
            end
            if (bus.upd_valid) begin
                pht[bus.upd_idx] <= upd_cnt;
                ghr              <= ghr_nxt;
            end
        end
    end
    assign bus.pred_valid = pv;
    assign bus.pred_taken = pt;
    assign bus.pred_idx   = pi;
    assign bus.ghr_out    = ghr;
endmodule

// File: tb/tb_gshare_predictor.sv
// tb_gshare_predictor: directed vectors, expected predictions queued and checked by a monitor.
module tb_gshare_predictor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    int pushed = 0;
    int popped = 0;
    logic [4:0] exp_q [$];
    gshare_if #(.PC_W(8), .IDX_W(4), .HIST_W(4)) bus ();
    gshare_predictor #(.PC_W(8), .IDX_W(4), .HIST_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
`ifdef GSHARE_FWD_EN
    localparam logic FWD_TAKEN = 1'b1;
`else
    localparam logic FWD_TAKEN = 1'b0;
`endif
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        bus.pred_req  = 1'b0;
        bus.upd_valid = 1'b0;
    endtask
    task automatic upd(input logic [3:0] i, input logic t);
        bus.upd_valid = 1'b1;
        bus.upd_idx   = i;
        bus.upd_taken = t;
        tick();
        idle();
    endtask
    task automatic req(input logic [7:0] pc, input logic [3:0] ei, input logic et);
        bus.pred_req = 1'b1;
        bus.pred_pc  = pc;
        exp_q.push_back({ei, et});
        pushed++;
        tick();
        idle();
    endtask
    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask
    // scoreboard monitor: every valid pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (bus.pred_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pred: got idx=%0h taken=%0b expected none",
                         bus.pred_idx, bus.pred_taken);
            end else begin
                logic [4:0] e;
                e = exp_q.pop_front();
                popped++;
                if ({bus.pred_idx, bus.pred_taken} != e) begin
                    bad++;
                    $display("FAIL pred#%0d: got idx=%0h taken=%0b expected idx=%0h taken=%0b",
                             popped, bus.pred_idx, bus.pred_taken, e[4:1], e[0]);
                end
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
    initial begin
        bus.pred_req = 0; bus.pred_pc = 0; bus.upd_valid = 0; bus.upd_idx = 0; bus.upd_taken = 0;
        tick();
        tick();
        rst = 1'b0;
        // T1 reset state
        chk("rst_valid", bus.pred_valid, 0);
        chk("rst_taken", bus.pred_taken, 0);
        chk("rst_idx", bus.pred_idx, 0);
        chk("rst_ghr", bus.ghr_out, 0);
        req(8'h05, 4'h5, 1'b0);
        chk("t1_ghr", bus.ghr_out, 0);
        tick();
        chk("t1_valid_drop", bus.pred_valid, 0);
        // T2 training and history
        upd(4'h5, 1'b1);
        chk("t2_ghr1", bus.ghr_out, 4'h1);
        upd(4'h5, 1'b1);
        chk("t2_ghr2", bus.ghr_out, 4'h3);
        req(8'h06, 4'h5, 1'b1);
        tick();
        // T3 saturation
        repeat (4) upd(4'h2, 1'b1);
        upd(4'h2, 1'b0);
        chk("t3_ghr_e", bus.ghr_out, 4'hE);
        do_reset();
        chk("t3_ghr_rst", bus.ghr_out, 0);
        repeat (4) upd(4'h2, 1'b1);
        upd(4'h2, 1'b0);
        req(8'h0C, 4'h2, 1'b1);
        repeat (5) upd(4'h9, 1'b0);
        chk("t3_ghr_0", bus.ghr_out, 0);
        req(8'h09, 4'h9, 1'b0);
        req(8'h02, 4'h2, 1'b1);
        tick();
        // T4 simultaneous prediction and update of the same entry
        bus.pred_req  = 1'b1;
        bus.pred_pc   = 8'h03;
        bus.upd_valid = 1'b1;
        bus.upd_idx   = 4'h3;
        bus.upd_taken = 1'b1;
        exp_q.push_back({4'h3, FWD_TAKEN});
        pushed++;
        tick();
        idle();
        chk("t4_ghr", bus.ghr_out, 4'h1);
        req(8'h02, 4'h3, 1'b1);
        tick();
        // T5 reset beats a same-cycle update and request
        rst           = 1'b1;
        bus.pred_req  = 1'b1;
        bus.pred_pc   = 8'h07;
        bus.upd_valid = 1'b1;
        bus.upd_idx   = 4'h7;
        bus.upd_taken = 1'b1;
        tick();
        idle();
        rst = 1'b0;
        chk("t5_valid", bus.pred_valid, 0);
        chk("t5_ghr", bus.ghr_out, 0);
        req(8'h07, 4'h7, 1'b0);
        tick();
        // T6 back-to-back with GHR=3 and PHT[4]=11
        upd(4'h4, 1'b1);
        upd(4'h4, 1'b1);
        for (int i = 0; i < 10; i++) begin
            logic [3:0] ei;
            ei = 4'(i) ^ 4'h3;
            bus.pred_req = 1'b1;
            bus.pred_pc  = 8'h20 + 8'(i);
            exp_q.push_back({ei, ei == 4'h4});
            pushed++;
            tick();
        end
        idle();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        tick();
        chk("queue_drained", exp_q.size(), 0);
        chk("pred_count", popped, pushed);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
